// File: rtl/demux1_4_stream.sv
// Registered 1-to-4 stream demux: {s2,s1} routes in_data into one of four single-entry output slots.
// Latency: 1 cycle (word accepted at edge N is visible on out_data/out_valid in cycle N+1).
// Backpressure: in_ready drops only when the selected slot is full and its consumer is not draining it.
// Optional feature macro: DEMUX_CNT_EN adds per-channel 8-bit wrapping delivered-word counters on cnt.
module demux1_4_stream #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               s1,
    input  logic               s2,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [31:0]        cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    logic [1:0]       sel;
    logic             accept;
    logic [3:0]       load;
    logic [3:0]       drain;
    state_t           state_q [4];
    state_t           state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [WIDTH-1:0] data_d  [4];

    // Input handshake: readiness looks only at the selected slot, never at in_valid
    always_comb begin
        load     = '0;
        drain    = '0;
        sel      = {s2, s1};
        in_ready = (state_q[sel] == EMPTY) || out_ready[sel];
        accept   = in_valid && in_ready;
        for (int k = 0; k < 4; k++) begin
            load[k]  = accept && (sel == 2'(k));
            drain[k] = (state_q[k] == FULL) && out_ready[k];
        end
    end

    // Per-slot next state: a load wins over a drain so drain+reload keeps the slot full
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            if (load[k]) begin
                state_d[k] = FULL;
                data_d[k]  = in_data;
            end else if (drain[k]) begin
                state_d[k] = EMPTY;
            end
        end
    end

    // Slot state and payload registers; reset discards any held words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
        end
    end

    // Pack slot registers onto the flat output buses
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int k = 0; k < 4; k++) begin
            out_valid[k]                = (state_q[k] == FULL);
            out_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

`ifdef DEMUX_CNT_EN
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];

    // Count each delivered word per channel; 8-bit wrap is intended
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k] + 8'(drain[k]);
        end
    end

    // Counter registers, cleared with the slots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Pack counters onto cnt
    always_comb begin
        cnt = '0;
        for (int k = 0; k < 4; k++) begin
            cnt[k*8 +: 8] = cnt_q[k];
        end
    end
`else
    assign cnt = '0;
`endif

endmodule

// File: tb/tb_demux1_4_stream.sv
// Self-checking bench for demux1_4_stream: directed scenarios followed by held-producer random traffic.
// Reference: four per-channel queues of words sent but not yet delivered, plus delivered-word counts.
// Inputs driven on the falling edge; outputs sampled 1 time unit later.
module tb_demux1_4_stream;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        s1;
    logic        s2;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [4][$];
    logic [7:0] cnt_m [4];

    logic       rdy;
    logic       acc;
    logic       rv;
    logic [1:0] rs;
    logic [7:0] rd;

    demux1_4_stream #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .s1        (s1),
        .s2        (s2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp();
        logic [31:0] v;
        v = '0;
`ifdef DEMUX_CNT_EN
        for (int k = 0; k < 4; k++) v[k*8 +: 8] = cnt_m[k];
`endif
        return v;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 4; k++) begin
            sb[k].delete();
            cnt_m[k] = 8'd0;
        end
    endfunction

    // One clock cycle: drive, check against the queues, advance the model, cross the edge
    task automatic step(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r,
                        output logic rdy_obs, output logic accepted);
        logic exp_rdy;
        in_valid  = v;
        {s2, s1}  = s;
        in_data   = d;
        out_ready = r;
        #1;
        exp_rdy = (sb[s].size() == 0) || r[s];
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        for (int k = 0; k < 4; k++) begin
            chk("out_valid", {31'd0, out_valid[k]}, {31'd0, sb[k].size() != 0});
            if (sb[k].size() != 0)
                chk("out_data", {24'd0, out_data[k*8 +: 8]}, {24'd0, sb[k][0]});
        end
        chk("cnt", cnt, cnt_exp());
        for (int k = 0; k < 4; k++) begin
            if (sb[k].size() != 0 && r[k]) begin
                void'(sb[k].pop_front());
                cnt_m[k] = cnt_m[k] + 8'd1;
            end
        end
        accepted = v && exp_rdy;
        if (accepted) sb[s].push_back(d);
        rdy_obs = in_ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_data   = '0;
        s1        = 1'b0;
        s2        = 1'b0;
        in_valid  = 1'b0;
        out_ready = '0;
        model_clear();

        // Reset state
        #1;
        chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_cnt", cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Routing to all four channels with consumers stalled
        step(1'b1, 2'd0, 8'hA0, 4'b0000, rdy, acc);
        step(1'b1, 2'd1, 8'hA1, 4'b0000, rdy, acc);
        step(1'b1, 2'd2, 8'hA2, 4'b0000, rdy, acc);
        step(1'b1, 2'd3, 8'hA3, 4'b0000, rdy, acc);
        chk("route_valid", {28'd0, out_valid}, 32'h0000_000F);
        chk("route_data", out_data, 32'hA3A2_A1A0);

        // Reset mid-run with all slots full
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_cnt", cnt, 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;

        // Back-pressure on channel 2, then drain and reload on the same edge
        step(1'b1, 2'd2, 8'h55, 4'b0000, rdy, acc);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'd2, 8'h66, 4'b0000, rdy, acc);
            chk("bp_stall", {31'd0, rdy}, 32'd0);
        end
        chk("bp_hold", {24'd0, out_data[23:16]}, 32'h55);
        step(1'b1, 2'd2, 8'h66, 4'b0100, rdy, acc);
        chk("bp_release", {31'd0, rdy}, 32'd1);
        chk("bp_stay_full", {31'd0, out_valid[2]}, 32'd1);
        chk("bp_new_word", {24'd0, out_data[23:16]}, 32'h66);
        step(1'b0, 2'd0, 8'h00, 4'b1111, rdy, acc);

        // Independence: stalled channel 1 does not block channel 3
        step(1'b1, 2'd1, 8'h22, 4'b0000, rdy, acc);
        step(1'b1, 2'd3, 8'h11, 4'b0000, rdy, acc);
        chk("indep_ready", {31'd0, rdy}, 32'd1);
        chk("indep_valid", {28'd0, out_valid}, 32'h0000_000A);
        chk("indep_ch1", {24'd0, out_data[15:8]}, 32'h22);
        chk("indep_ch3", {24'd0, out_data[31:24]}, 32'h11);
        step(1'b0, 2'd0, 8'h00, 4'b1111, rdy, acc);

        // Streaming 300 words to channel 0 at full rate
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 2'd0, 8'(i), 4'b1111, rdy, acc);
            chk("stream_ready", {31'd0, rdy}, 32'd1);
        end
        step(1'b0, 2'd0, 8'h00, 4'b1111, rdy, acc);
`ifdef DEMUX_CNT_EN
        chk("stream_cnt0", {24'd0, cnt[7:0]}, 32'd44);
`else
        chk("stream_cnt0", {24'd0, cnt[7:0]}, 32'd0);
`endif

        // Random traffic; producer holds its word until accepted
        rv  = 1'b0;
        rs  = 2'd0;
        rd  = 8'd0;
        acc = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if (acc || !rv) begin
                rv = ($urandom_range(0, 3) != 0);
                rs = 2'($urandom_range(0, 3));
                rd = 8'($urandom);
            end
            step(rv, rs, rd, 4'($urandom_range(0, 15)), rdy, acc);
        end
        step(1'b0, 2'd0, 8'h00, 4'b1111, rdy, acc);
        step(1'b0, 2'd0, 8'h00, 4'b1111, rdy, acc);
        chk("final_empty", {28'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
